// File: rtl/alu_pkg.sv
// alu_pkg: operation encoding and FSM state type shared by the ALU control
// decoder (producer of selec) and alu_seq (consumer of selec).
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [2:0] ALU_MULT = 3'd5;
    localparam logic [2:0] ALU_DIV  = 3'd6;
    localparam logic [2:0] ALU_NOP  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiply / restoring divide datapath,
// one bit per clock.
//   clk, rst   clock, async active-high reset (clears all state)
//   load       capture a/b and arm the counter with WIDTH
//   div_mode   1 = divide step, 0 = multiply step (selects the step logic)
//   a, b       operands (a = multiplier / dividend, b = multiplicand / divisor)
//   last       high during the final step (counter == 1)
//   nxt_hi     value hi takes at the coming step (product high / remainder)
//   nxt_lo     value lo takes at the coming step (product low / quotient)
// Both operations share the same {hi, lo} register pair: lo starts as a and
// is consumed one bit per step while the result bits shift in.
module alu_muldiv_iter import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign last = (cnt == CNT_W'(1));

    always_comb begin
        // Multiply: conditionally add multiplicand, then shift {sum, lo} right.
        sum     = {1'b0, acc} + ({1'b0, opb} & {(WIDTH + 1){lo[0]}});
        // Divide: bring the next dividend bit into the partial remainder.
        // shifted <= 2*divisor-1, so a non-negative trial always fits WIDTH bits
        // and trial[WIDTH] is a clean borrow flag.
        shifted = {acc, lo[WIDTH-1]};
        trial   = shifted - {1'b0, opb};
        if (div_mode) begin
            if (!trial[WIDTH]) begin
                nxt_hi = trial[WIDTH-1:0];
                nxt_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
            lo  <= '0;
            opb <= '0;
        end else if (load) begin
            cnt <= CNT_W'(WIDTH);
            acc <= '0;
            lo  <= a;
            opb <= b;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            acc <= nxt_hi;
            lo  <= nxt_lo;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle EX-stage execution unit.
//   clk, rst   clock, async active-high reset
//   start      request, accepted on an edge where ready=1
//   selec      operation code (alu_pkg ALU_*), sampled at accept
//   A, B       operands, sampled at accept
//   ready      1 while idle; the pipeline stalls while it is low
//   done       registered one-cycle pulse per completed operation
//   result     main result / low product word / quotient
//   hi         high product word / remainder; untouched by other ops
//   zero       registered (result == 0), updated together with result
// Single-cycle ops complete at the accept edge; mult/div run WIDTH steps in
// alu_muldiv_iter and complete on the edge the step counter reaches zero.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       selec,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero
);

    state_t           state_q, state_d;
    logic             load;
    logic             wr_res;
    logic             wr_hi;
    logic             done_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] hi_d;
    logic             last;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    assign ready = (state_q == S_IDLE);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .div_mode (state_q == S_DIV),
        .a        (A),
        .b        (B),
        .last     (last),
        .nxt_hi   (nxt_hi),
        .nxt_lo   (nxt_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        wr_res  = 1'b0;
        wr_hi   = 1'b0;
        done_d  = 1'b0;
        res_d   = result;
        hi_d    = hi;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    case (selec)
                        ALU_ADD: begin wr_res = 1'b1; res_d = A + B; end
                        ALU_SUB: begin wr_res = 1'b1; res_d = A - B; end
                        ALU_OR:  begin wr_res = 1'b1; res_d = A | B; end
                        ALU_AND: begin wr_res = 1'b1; res_d = A & B; end
                        ALU_SLT: begin
                            wr_res = 1'b1;
                            res_d  = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
                        end
                        ALU_MULT: begin
                            state_d = S_MUL;
                            load    = 1'b1;
                            done_d  = 1'b0;
                        end
                        ALU_DIV: begin
                            if (B == '0) begin
                                // Divide by zero resolves immediately: all-ones quotient, remainder = A.
                                wr_res = 1'b1;
                                wr_hi  = 1'b1;
                                res_d  = '1;
                                hi_d   = A;
                            end else begin
                                state_d = S_DIV;
                                load    = 1'b1;
                                done_d  = 1'b0;
                            end
                        end
                        default: ;  // NOP: pulse done only
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (last) begin
                    state_d = S_IDLE;
                    wr_res  = 1'b1;
                    wr_hi   = 1'b1;
                    done_d  = 1'b1;
                    res_d   = nxt_lo;
                    hi_d    = nxt_hi;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b1;
        end else begin
            done <= done_d;
            if (wr_res) begin
                result <= res_d;
                zero   <= (res_d == '0);
            end
            if (wr_hi) hi <= hi_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven bench for alu_seq (WIDTH=32).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   selec;
    logic [W-1:0] A, B;
    logic         ready, done, zero;
    logic [W-1:0] result, hi;

    int n_chk  = 0;
    int n_pass = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .selec  (selec),
        .A      (A),
        .B      (B),
        .ready  (ready),
        .done   (done),
        .result (result),
        .hi     (hi),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
    } vec_t;

    vec_t sv[11];
    vec_t mv[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        selec = s;
        A     = a;
        B     = b;
    endtask

    // Called 1 unit after the accept edge; returns edges until done and the
    // number of sampled cycles with ready low. Optionally pokes start mid-op.
    task automatic wait_done(input bit inject, output int n, output int low);
        n   = 0;
        low = 0;
        while (!done && n < 40) begin
            if (!ready) low++;
            if (inject && n == 10) drive(ALU_ADD, 32'd1, 32'd1);
            if (n == 12) start = 1'b0;
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, low;
        rst = 1'b1; start = 1'b0; selec = '0; A = '0; B = '0;

        // sel, A, B, result, hi, zero -- hi tracks what earlier rows left behind
        sv[0]  = '{ALU_ADD, 32'd5,          32'd7,          32'd12,         32'd0, 1'b0};
        sv[1]  = '{ALU_SUB, 32'd9,          32'd9,          32'd0,          32'd0, 1'b1};
        sv[2]  = '{ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          32'd0, 1'b0};
        sv[3]  = '{ALU_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          32'd0, 1'b1};
        sv[4]  = '{ALU_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  32'd0, 1'b0};
        sv[5]  = '{ALU_OR,  32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F,  32'd0, 1'b0};
        sv[6]  = '{ALU_AND, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  32'd0, 1'b0};
        sv[7]  = '{ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0, 1'b1};
        sv[8]  = '{ALU_DIV, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5, 1'b0};
        sv[9]  = '{ALU_SLT, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          32'd5, 1'b0};
        sv[10] = '{ALU_NOP, 32'd3,          32'd3,          32'd1,          32'd5, 1'b0};

        mv[0] = '{ALU_MULT, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 32'h0000_0001, 1'b0};
        mv[1] = '{ALU_DIV,  32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        mv[2] = '{ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        mv[3] = '{ALU_DIV,  32'd3,         32'd7,         32'd0,         32'd3,         1'b1};
        mv[4] = '{ALU_MULT, 32'd0,         32'd5,         32'd0,         32'd0,         1'b1};
        mv[5] = '{ALU_DIV,  32'd7,         32'd1,         32'd7,         32'd0,         1'b0};
        mv[6] = '{ALU_DIV,  32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 32'd5,         1'b0};

        tick(); tick();
        chk("rst_ready",  ready,  1);
        chk("rst_done",   done,   0);
        chk("rst_result", result, 0);
        chk("rst_hi",     hi,     0);
        chk("rst_zero",   zero,   1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            drive(sv[i].sel, sv[i].a, sv[i].b);
            tick();
            start = 1'b0;
            chk($sformatf("sv%0d_done", i),   done,   1);
            chk($sformatf("sv%0d_ready", i),  ready,  1);
            chk($sformatf("sv%0d_result", i), result, sv[i].res);
            chk($sformatf("sv%0d_hi", i),     hi,     sv[i].hi);
            chk($sformatf("sv%0d_zero", i),   zero,   sv[i].zero);
            tick();
            chk($sformatf("sv%0d_done_drop", i), done, 0);
        end

        for (int i = 0; i < 7; i++) begin
            drive(mv[i].sel, mv[i].a, mv[i].b);
            tick();
            start = 1'b0;
            wait_done(i < 2, n, low);
            chk($sformatf("mv%0d_latency", i),   n,      W);
            chk($sformatf("mv%0d_ready_low", i), low,    W);
            chk($sformatf("mv%0d_result", i),    result, mv[i].res);
            chk($sformatf("mv%0d_hi", i),        hi,     mv[i].hi);
            chk($sformatf("mv%0d_zero", i),      zero,   mv[i].zero);
            tick();
            chk($sformatf("mv%0d_done_drop", i), done,   0);
            chk($sformatf("mv%0d_ready", i),     ready,  1);
        end

        // Reset in the middle of a multiply.
        drive(ALU_MULT, 32'd3, 32'd4);
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("mid_busy", ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready",  ready,  1);
        chk("mid_rst_done",   done,   0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_hi",     hi,     0);
        chk("mid_rst_zero",   zero,   1);
        tick();
        rst = 1'b0;
        tick();
        drive(ALU_ADD, 32'd1, 32'd1);
        tick();
        start = 1'b0;
        chk("post_rst_done",   done,   1);
        chk("post_rst_result", result, 2);
        tick();
        chk("post_rst_done_drop", done, 0);

        // Back-to-back: ADD accepted in the MULT done cycle, then NOP.
        drive(ALU_MULT, 32'd2, 32'd3);
        tick();
        start = 1'b0;
        wait_done(1'b0, n, low);
        chk("b2b_mul_latency", n,      W);
        chk("b2b_mul_result",  result, 6);
        chk("b2b_mul_ready",   ready,  1);
        drive(ALU_ADD, 32'd1, 32'd2);
        tick();
        start = 1'b0;
        chk("b2b_add_done",   done,   1);
        chk("b2b_add_result", result, 3);
        chk("b2b_add_hi",     hi,     0);
        tick();
        chk("b2b_done_drop", done, 0);
        drive(ALU_NOP, 32'd9, 32'd9);
        tick();
        start = 1'b0;
        chk("nop_done",   done,   1);
        chk("nop_result", result, 3);
        chk("nop_zero",   zero,   0);
        chk("nop_hi",     hi,     0);
        tick();
        chk("nop_done_drop", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
